// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART receive frame controller
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_CSUM    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_LINE    = 2'd3
    } err_code_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload byte store with one write port and asynchronous read
module uart_frame_buf #(
    parameter int MAX_LEN = 16,
    parameter int PW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] wr_ptr,
    input  logic [7:0]    wdata,
    input  logic [PW-1:0] rd_ptr,
    output logic [7:0]    rdata
);

    logic [7:0] r_mem [MAX_LEN];

    // Write the addressed entry; the decode loop keeps pointer width independent of depth
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_LEN; i++) begin
            if (we && (wr_ptr == PW'(i))) begin
                r_mem[i] <= wdata;
            end
        end
    end

    // Combinational read of the entry under the read pointer
    always_comb begin
        rdata = 8'h00;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (rd_ptr == PW'(i)) begin
                rdata = r_mem[i];
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - frames the uart_rx byte stream, validates it and drains good payloads
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       rx_error,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int              LW         = $clog2(MAX_LEN + 1);
    localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      MAX_LEN_B  = 8'(MAX_LEN);
    localparam logic [TW-1:0]   TMO_RELOAD = TW'(TIMEOUT_CYCLES);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_rx_ready_q;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_wr_ptr;
    logic [LW-1:0] r_rd_ptr;
    logic [7:0]    r_sum;
    logic [TW-1:0] r_tmo;
    logic          r_frame_ok;
    logic          r_frame_err;
    err_code_t     r_err_code;

    logic          w_byte_evt;
    logic          w_len_bad;
    logic [7:0]    w_sum_chk;
    logic          w_timed;
    logic          w_tmo_expire;
    logic          w_xfer;
    logic          w_last;
    logic [7:0]    w_rdata;
    logic          w_err_set;
    err_code_t     w_err_code_nxt;
    logic          w_ok_set;
    logic          w_len_load;
    logic          w_buf_we;

    assign w_byte_evt   = rx_ready & ~r_rx_ready_q;
    assign w_len_bad    = (rx_data == 8'h00) || (rx_data > MAX_LEN_B);
    assign w_sum_chk    = r_sum + rx_data;
    assign w_timed      = (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CSUM);
    // Fires on the cycle whose decrement would land on zero, so the error
    // pulse appears TIMEOUT_CYCLES+1 cycles after the last byte event
    assign w_tmo_expire = w_timed && (r_tmo <= TW'(1));
    assign w_xfer       = (r_state == DRAIN) && out_ready;
    assign w_last       = (r_rd_ptr == (r_len - LW'(1)));

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN),
        .PW      (LW)
    ) u_buf (
        .clk    (clk),
        .we     (w_buf_we),
        .wr_ptr (r_wr_ptr),
        .wdata  (rx_data),
        .rd_ptr (r_rd_ptr),
        .rdata  (w_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle control; inside a frame a line error beats a byte event, which beats timeout
    always_comb begin
        w_state_nxt    = r_state;
        w_err_set      = 1'b0;
        w_err_code_nxt = ERR_CSUM;
        w_ok_set       = 1'b0;
        w_len_load     = 1'b0;
        w_buf_we       = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_byte_evt && (rx_data == SYNC_BYTE)) begin
                    w_state_nxt = LEN;
                end
            end
            LEN: begin
                if (rx_error) begin
                    w_err_set      = 1'b1;
                    w_err_code_nxt = ERR_LINE;
                    w_state_nxt    = HUNT;
                end else if (w_byte_evt) begin
                    if (w_len_bad) begin
                        w_err_set      = 1'b1;
                        w_err_code_nxt = ERR_LEN;
                        w_state_nxt    = HUNT;
                    end else begin
                        w_len_load  = 1'b1;
                        w_state_nxt = PAYLOAD;
                    end
                end else if (w_tmo_expire) begin
                    w_err_set      = 1'b1;
                    w_err_code_nxt = ERR_TIMEOUT;
                    w_state_nxt    = HUNT;
                end
            end
            PAYLOAD: begin
                if (rx_error) begin
                    w_err_set      = 1'b1;
                    w_err_code_nxt = ERR_LINE;
                    w_state_nxt    = HUNT;
                end else if (w_byte_evt) begin
                    w_buf_we = 1'b1;
                    if (r_wr_ptr == (r_len - LW'(1))) begin
                        w_state_nxt = CSUM;
                    end
                end else if (w_tmo_expire) begin
                    w_err_set      = 1'b1;
                    w_err_code_nxt = ERR_TIMEOUT;
                    w_state_nxt    = HUNT;
                end
            end
            CSUM: begin
                if (rx_error) begin
                    w_err_set      = 1'b1;
                    w_err_code_nxt = ERR_LINE;
                    w_state_nxt    = HUNT;
                end else if (w_byte_evt) begin
                    if (w_sum_chk == 8'h00) begin
                        w_ok_set    = 1'b1;
                        w_state_nxt = DRAIN;
                    end else begin
                        w_err_set      = 1'b1;
                        w_err_code_nxt = ERR_CSUM;
                        w_state_nxt    = HUNT;
                    end
                end else if (w_tmo_expire) begin
                    w_err_set      = 1'b1;
                    w_err_code_nxt = ERR_TIMEOUT;
                    w_state_nxt    = HUNT;
                end
            end
            DRAIN: begin
                // A byte arriving while draining has nowhere to go; report it and keep draining
                if (w_byte_evt) begin
                    w_err_set      = 1'b1;
                    w_err_code_nxt = ERR_LINE;
                end
                if (w_xfer && w_last) begin
                    w_state_nxt = HUNT;
                end
            end
            default: begin
                w_state_nxt = HUNT;
            end
        endcase
    end

    // Edge detect, status pulses, length/checksum/pointer bookkeeping and the inter-byte timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ready_q <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_code   <= ERR_CSUM;
            r_len        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_sum        <= 8'h00;
            r_tmo        <= '0;
        end else begin
            r_rx_ready_q <= rx_ready;
            r_frame_ok   <= w_ok_set;
            r_frame_err  <= w_err_set;
            if (w_err_set) begin
                r_err_code <= w_err_code_nxt;
            end
            if (w_len_load) begin
                r_len    <= rx_data[LW-1:0];
                r_sum    <= rx_data;
                r_wr_ptr <= '0;
            end else if (w_buf_we) begin
                r_sum    <= w_sum_chk;
                r_wr_ptr <= r_wr_ptr + LW'(1);
            end
            if (w_ok_set) begin
                r_rd_ptr <= '0;
            end else if (w_xfer) begin
                r_rd_ptr <= r_rd_ptr + LW'(1);
            end
            // The SYNC event in HUNT also reloads, which covers the entry into LEN
            if (w_byte_evt) begin
                r_tmo <= TMO_RELOAD;
            end else if (w_timed && (r_tmo != '0)) begin
                r_tmo <= r_tmo - TW'(1);
            end
        end
    end

    assign out_valid = (r_state == DRAIN);
    assign out_data  = out_valid ? w_rdata : 8'h00;
    assign out_last  = out_valid & w_last;
    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;
    assign err_code  = r_err_code;
    assign busy      = (r_state != HUNT);

endmodule
